instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Instruction fetch stage of the multicycle MIPS datapath; sits directly upstream of the immediate extender.
//  Holds the PC and fetches one word per request from instruction memory over a req/ready handshake.
//  Latches the word into IR and presents imm16 plus the decoded ExtOp to the extender.
//  Accepts branch/jump redirects, computing branch targets from the extender's 32-bit output.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset; must be word aligned.
// PORTS
//  clk            in   1   system clock; all state updates on rising edge
//  rst_n          in   1   asynchronous active-low reset
//  imem_req       out  1   fetch request to instruction memory
//  imem_addr      out  32  fetch byte address (= pc; bits [1:0] always 00)
//  imem_rdata     in   32  instruction word, valid when imem_ready=1
//  imem_ready     in   1   memory completes request this cycle (req&ready)
//  ir             out  32  instruction register
//  ir_pc          out  32  address ir was fetched from
//  ir_valid       out  1   ir holds an instruction not yet taken by decode
//  dec_ready      in   1   decode consumes ir this cycle (effective only with ir_valid)
//  imm16          out  16  ir[15:0], feeds extender imm16
//  ext_op         out  1   1=sign-extend, 0=zero-extend, feeds extender ExtOp
//  redirect       in   1   decode requests PC change for the consumed instruction
//  redirect_kind  in   1   0=branch (PC-relative), 1=jump (pseudo-direct)
//  ext_imm        in   32  extender output for the consumed branch
//  jump_idx       in   26  ir[25:0] index of the consumed jump
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, imem_req=0, ir=0, ir_pc=0, ir_valid=0.
//    Takes effect immediately, including mid-request; any response already in flight is discarded.
//  imem_req is registered-clean: 0 while rst_n=0, then 1 from the first cycle in FETCH.
//  FSM, 2 states:
//   FETCH: imem_req=1, imem_addr=pc, held stable until imem_ready.
//     imem_ready=1 -> ir<=imem_rdata, ir_pc<=pc, pc<=pc+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), ir_valid<=1 -> VALID.
//     imem_ready=0 -> stay; any number of wait cycles allowed, including zero (ready in the first FETCH cycle).
//   VALID: imem_req=0; ir, ir_pc, ir_valid held stable while dec_ready=0 (backpressure).
//     dec_ready=1 -> ir_valid<=0 -> FETCH; if redirect=1 in the same cycle, pc<=target.
//  Redirect targets (npc = ir_pc+4, mod 2^32):
//    branch = npc + (ext_imm<<2), mod 2^32
//    jump   = {npc[31:28], jump_idx, 2'b00}
//  No delay slot: the instruction at npc is not fetched when a redirect is taken.
//  redirect is ignored unless ir_valid & dec_ready; dec_ready is ignored in FETCH.
//  Latency: first request 1 cycle after rst_n rises; ir_valid rises the cycle after req&ready.
//  Peak throughput is 1 instruction per 2 cycles.
//  ext_op is combinational from ir[31:26]:
//    1 for 0x04 beq, 0x05 bne, 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x23 lw, 0x2B sw.
//    0 for all other opcodes, including andi/ori/xori/lui and R-type.
//  imm16 = ir[15:0] at all times; both outputs are meaningful only when ir_valid=1.
// TESTING
//  1 Reset release, memory ready in first cycle -> imem_req=1 with addr 0x3000 one cycle after rst_n rises;
//    ir_valid=1 next cycle; following fetch at 0x3004.
//  2 Memory with 3 wait cycles -> imem_addr stable 4 cycles; ir captures only the word presented with ready.
//  3 dec_ready low 5 cycles in VALID -> ir/ir_pc/ir_valid unchanged, imem_req=0; next fetch only after dec_ready.
//  4 beq at ir_pc=0x3008, redirect=1, kind=0, ext_imm=0xFFFF_FFFE -> next imem_addr=0x3004;
//    addi 0x2008FFFF -> ext_op=1, imm16=0xFFFF; ori -> ext_op=0.
//  5 j at ir_pc=0x3010, kind=1, jump_idx=26'h0000C10 -> next imem_addr=0x0000_3040;
//    redirect with dec_ready=0 -> no effect.
//  6 RESET_PC=0xFFFF_FFFC -> second fetch addr 0x0000_0000;
//    rst_n low during a wait cycle -> imem_req and ir_valid drop at once, restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus: one outstanding word request, completed by req & ready.
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, output addr, input rdata, input ready);
  modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/instr_fetch.sv
// Multicycle MIPS fetch stage: PC, IR capture over a req/ready bus, branch/jump redirect,
// and the imm16/ext_op feed for the immediate extender.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      imem,
  output logic [31:0]        ir,
  output logic [31:0]        ir_pc,
  output logic               ir_valid,
  input  logic               dec_ready,
  output logic [15:0]        imm16,
  output logic               ext_op,
  input  logic               redirect,
  input  logic               redirect_kind,
  input  logic [31:0]        ext_imm,
  input  logic [25:0]        jump_idx
);

  typedef enum logic {
    FETCH = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic        req_reg;
  logic [31:0] ir_reg;
  logic [31:0] ir_pc_reg;
  logic        ir_valid_reg;

  logic [31:0] npc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;

  // Targets are relative to the consumed instruction, not to the already-advanced pc.
  assign npc             = ir_pc_reg + 32'd4;
  assign branch_target   = npc + (ext_imm << 2);
  assign jump_target     = {npc[31:28], jump_idx, 2'b00};
  assign redirect_target = redirect_kind ? jump_target : branch_target;

  // req_reg is cleared by reset, so the first FETCH cycle after release never captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FETCH;
      pc_reg       <= RESET_PC;
      req_reg      <= 1'b0;
      ir_reg       <= 32'd0;
      ir_pc_reg    <= 32'd0;
      ir_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (req_reg && imem.ready) begin
            ir_reg       <= imem.rdata;
            ir_pc_reg    <= pc_reg;
            pc_reg       <= pc_reg + 32'd4;
            ir_valid_reg <= 1'b1;
            req_reg      <= 1'b0;
            state_reg    <= VALID;
          end else begin
            req_reg      <= 1'b1;
          end
        end
        VALID: begin
          if (dec_ready) begin
            ir_valid_reg <= 1'b0;
            req_reg      <= 1'b1;
            state_reg    <= FETCH;
            if (redirect) begin
              pc_reg <= redirect_target;
            end
          end
        end
        default: begin
          state_reg <= FETCH;
        end
      endcase
    end
  end

  assign imem.req  = req_reg;
  assign imem.addr = pc_reg;
  assign ir        = ir_reg;
  assign ir_pc     = ir_pc_reg;
  assign ir_valid  = ir_valid_reg;
  assign imm16     = ir_reg[15:0];

  // Sign-extend for arithmetic immediates, branch offsets and load/store displacements.
  always_comb begin
    ext_op = 1'b0;
    case (ir_reg[31:26])
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B: ext_op = 1'b1;
      default: ext_op = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level PC/IR model.
module tb_instr_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n2;
  logic [31:0] ir, ir_pc, ir2, ir_pc2;
  logic        ir_valid, ir_valid2;
  logic        dec_ready, dec_ready2;
  logic [15:0] imm16, imm16_2;
  logic        ext_op, ext_op2;
  logic        redirect, redirect2;
  logic        redirect_kind, redirect_kind2;
  logic [31:0] ext_imm, ext_imm2;
  logic [25:0] jump_idx, jump_idx2;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .dec_ready(dec_ready),
    .imm16(imm16), .ext_op(ext_op), .redirect(redirect), .redirect_kind(redirect_kind),
    .ext_imm(ext_imm), .jump_idx(jump_idx)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n2), .imem(bus2),
    .ir(ir2), .ir_pc(ir_pc2), .ir_valid(ir_valid2), .dec_ready(dec_ready2),
    .imm16(imm16_2), .ext_op(ext_op2), .redirect(redirect2), .redirect_kind(redirect_kind2),
    .ext_imm(ext_imm2), .jump_idx(jump_idx2)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_pc;
  logic [5:0]  ops [10] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h0D, 6'h00};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_ext_op(input logic [31:0] w);
    return w[31:26] inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B};
  endfunction

  // One full fetch/decode round trip, exp_pc advanced by the architectural next-PC rule.
  task automatic do_txn(input logic [31:0] word, input int waits, input int stalls,
                        input logic redir, input logic kind,
                        input logic [31:0] eimm, input logic [25:0] jidx);
    logic [31:0] npc, nxt;
    check_eq("req_start", {31'd0, bus.req}, 32'd1);
    check_eq("addr_start", bus.addr, exp_pc);
    for (int i = 0; i < waits; i++) begin
      bus.ready = 1'b0;
      bus.rdata = $urandom;
      step();
      check_eq("wait_req", {31'd0, bus.req}, 32'd1);
      check_eq("wait_addr", bus.addr, exp_pc);
      check_eq("wait_ir_valid", {31'd0, ir_valid}, 32'd0);
    end
    bus.ready = 1'b1;
    bus.rdata = word;
    step();
    bus.ready = 1'b0;
    bus.rdata = $urandom;
    check_eq("ir_valid", {31'd0, ir_valid}, 32'd1);
    check_eq("ir", ir, word);
    check_eq("ir_pc", ir_pc, exp_pc);
    check_eq("imm16", {16'd0, imm16}, {16'd0, word[15:0]});
    check_eq("ext_op", {31'd0, ext_op}, {31'd0, model_ext_op(word)});
    check_eq("valid_req", {31'd0, bus.req}, 32'd0);
    for (int i = 0; i < stalls; i++) begin
      dec_ready     = 1'b0;
      redirect      = 1'($urandom);
      redirect_kind = 1'($urandom);
      ext_imm       = $urandom;
      jump_idx      = 26'($urandom);
      step();
      check_eq("stall_ir", ir, word);
      check_eq("stall_ir_pc", ir_pc, exp_pc);
      check_eq("stall_ir_valid", {31'd0, ir_valid}, 32'd1);
      check_eq("stall_req", {31'd0, bus.req}, 32'd0);
    end
    npc = exp_pc + 32'd4;
    if (!redir)     nxt = npc;
    else if (kind)  nxt = {npc[31:28], jidx, 2'b00};
    else            nxt = npc + eimm * 32'd4;
    dec_ready     = 1'b1;
    redirect      = redir;
    redirect_kind = kind;
    ext_imm       = eimm;
    jump_idx      = jidx;
    step();
    dec_ready = 1'b0;
    redirect  = 1'b0;
    check_eq("consumed_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("next_req", {31'd0, bus.req}, 32'd1);
    check_eq("next_addr", bus.addr, nxt);
    $display("txn pc=%h word=%h waits=%0d stalls=%0d redir=%0b kind=%0b next=%h",
             exp_pc, word, waits, stalls, redir, kind, nxt);
    exp_pc = nxt;
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; rst_n2 = 1'b0;
    bus.ready = 1'b0; bus.rdata = 32'd0;
    dec_ready = 1'b0; redirect = 1'b0; redirect_kind = 1'b0; ext_imm = 32'd0; jump_idx = 26'd0;
    bus2.ready = 1'b1; bus2.rdata = 32'h2008_FFFF;
    dec_ready2 = 1'b1; redirect2 = 1'b0; redirect_kind2 = 1'b0; ext_imm2 = 32'd0; jump_idx2 = 26'd0;
    step();
    step();
    check_eq("rst_req", {31'd0, bus.req}, 32'd0);
    check_eq("rst_addr", bus.addr, 32'h0000_3000);
    check_eq("rst_ir", ir, 32'd0);
    check_eq("rst_ir_pc", ir_pc, 32'd0);
    check_eq("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("rst_req2", {31'd0, bus2.req}, 32'd0);

    // Wrapping reset PC: second fetch must land on address zero.
    rst_n2 = 1'b1;
    step();
    check_eq("wrap_req", {31'd0, bus2.req}, 32'd1);
    check_eq("wrap_addr0", bus2.addr, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_ir_valid", {31'd0, ir_valid2}, 32'd1);
    check_eq("wrap_ir_pc", ir_pc2, 32'hFFFF_FFFC);
    check_eq("wrap_ir", ir2, 32'h2008_FFFF);
    check_eq("wrap_imm16", {16'd0, imm16_2}, 32'h0000_FFFF);
    check_eq("wrap_ext_op", {31'd0, ext_op2}, 32'd1);
    step();
    check_eq("wrap_req1", {31'd0, bus2.req}, 32'd1);
    check_eq("wrap_addr1", bus2.addr, 32'h0000_0000);
    rst_n2 = 1'b0;

    rst_n = 1'b1;
    step();
    exp_pc = 32'h0000_3000;
    do_txn(32'h3408_0001, 0, 0, 1'b0, 1'b0, 32'd0, 26'd0);          // ori @3000
    do_txn(32'h2008_FFFF, 3, 5, 1'b0, 1'b0, 32'd0, 26'd0);          // addi @3004
    do_txn(32'h1000_FFFE, 1, 2, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'd0);  // beq @3008 -> 3004
    do_txn(32'h8C08_0004, 0, 1, 1'b0, 1'b0, 32'd0, 26'd0);          // lw @3004
    do_txn(32'h3C08_1234, 2, 0, 1'b0, 1'b0, 32'd0, 26'd0);          // lui @3008
    do_txn(32'h0000_0020, 0, 0, 1'b0, 1'b0, 32'd0, 26'd0);          // add @300C
    do_txn(32'h0800_0C10, 1, 3, 1'b1, 1'b1, 32'd0, 26'h0000C10);    // j @3010 -> 3040

    for (int t = 0; t < 40; t++) begin
      w = $urandom;
      if ($urandom_range(1) == 1) w[31:26] = ops[$urandom_range(9)];
      do_txn(w, int'($urandom_range(3)), int'($urandom_range(3)),
             1'($urandom), 1'($urandom),
             32'($signed(16'($urandom))), 26'($urandom));
    end

    // Asynchronous reset in the middle of a wait cycle.
    bus.ready = 1'b0;
    step();
    check_eq("pre_rst_req", {31'd0, bus.req}, 32'd1);
    #2;
    rst_n = 1'b0;
    bus.ready = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("async_req", {31'd0, bus.req}, 32'd0);
    check_eq("async_ir_valid", {31'd0, ir_valid}, 32'd0);
    check_eq("async_addr", bus.addr, 32'h0000_3000);
    step();
    rst_n = 1'b1;
    step();
    check_eq("release_no_capture", {31'd0, ir_valid}, 32'd0);
    bus.ready = 1'b0;
    exp_pc = 32'h0000_3000;
    do_txn(32'h2409_0007, 1, 0, 1'b0, 1'b0, 32'd0, 26'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
